// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types for the pipeline hazard controller
// Purpose: controller state type and register-index type shared by the
//          hazard interface and the hazard controller.
// Ports:   none (package)
package hazard_ctrl_pkg;

  // 5-bit architectural register index
  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard sources in, latch/PC control pins out
// Purpose: bundles the datapath-to-controller hazard sources and the
//          controller-to-datapath enable/flush pins.
// Ports:   master - the hazard controller (reads sources, drives controls)
//          slave  - the datapath latches and PC (drive sources, read controls)
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
();
  logic     ihit;
  logic     dhit;
  regbits_t ifid_rs;
  regbits_t ifid_rt;
  logic     idex_DRen;
  regbits_t idex_wsel;
  logic     ex_redirect;
  logic     exmem_dREN;
  logic     exmem_dWEN;
  logic     mem_halt;
  logic     pc_en;
  logic     ifid_en;
  logic     ifid_flush;
  logic     idex_en;
  logic     idex_flush;
  logic     exmem_en;
  logic     exmem_flush;
  logic     memwb_en;
  logic     halt;

  modport master (
    input  ihit, dhit, ifid_rs, ifid_rt, idex_DRen, idex_wsel, ex_redirect,
           exmem_dREN, exmem_dWEN, mem_halt,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           exmem_flush, memwb_en, halt
  );

  modport slave (
    output ihit, dhit, ifid_rs, ifid_rt, idex_DRen, idex_wsel, ex_redirect,
           exmem_dREN, exmem_dWEN, mem_halt,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           exmem_flush, memwb_en, halt
  );
endinterface

// File: rtl/hazard_ctrl_perf_cnt.sv
// rtl/hazard_ctrl_perf_cnt.sv - saturating performance counter
// Purpose: counts cycles with inc=1, holds at all-ones instead of wrapping.
// Ports:   clk - clock
//          rst - synchronous active-high clear
//          inc - count this cycle
//          cnt - current count
module hazard_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard / stall / flush / halt-drain controller
// Purpose: drives PC and pipeline latch enables/flushes from load-use, redirect,
//          cache-miss and halt conditions; drains the pipeline on halt.
//          Optional macro HAZARD_PERF_EN enables the performance counters;
//          without it stall_cnt/flush_cnt read 0.
// Ports:   CLK       - clock
//          RST       - synchronous active-high reset
//          hz        - hazard_ctrl_if.master (sources in, controls and halt out)
//          stall_cnt - cycles with pc_en=0 outside HALTED (saturating)
//          flush_cnt - redirect flushes taken (saturating)
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int PERF_W       = 32
) (
  input  logic              CLK,
  input  logic              RST,
  hazard_ctrl_if.master     hz,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  localparam logic [1:0] S_RUN     = RUN;
  localparam logic [1:0] S_MEMWAIT = MEMWAIT;
  localparam logic [1:0] S_DRAIN   = DRAIN;
  localparam logic [1:0] S_HALTED  = HALTED;
  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  logic [1:0]    state, next_state;
  logic [CW-1:0] drain_cnt;
  logic          halt_q;
  logic          load_use, mem_busy, apply_flow;
  logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic          exmem_en, exmem_flush, memwb_en;

  assign load_use = hz.idex_DRen && (hz.idex_wsel != '0) &&
                    ((hz.idex_wsel == hz.ifid_rs) || (hz.idex_wsel == hz.ifid_rt));
  assign mem_busy = (hz.exmem_dREN || hz.exmem_dWEN) && !hz.dhit;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    next_state  = state;
    apply_flow  = 1'b0;
    if (RST) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      {ifid_flush, idex_flush, exmem_flush}         = '1;
      next_state = S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          if (hz.mem_halt) begin
            pc_en       = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            next_state  = S_DRAIN;
          end else if (mem_busy) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            next_state = S_MEMWAIT;
          end else begin
            apply_flow = 1'b1;
          end
        end
        S_MEMWAIT: begin
          // A redirect sitting in EX is ignored until the access completes.
          if (hz.dhit) begin
            apply_flow = 1'b1;
            next_state = S_RUN;
          end else begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
          end
        end
        S_DRAIN: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          if (drain_cnt == '0) next_state = S_HALTED;
        end
        default: begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        end
      endcase
      if (apply_flow) begin
        if (hz.ex_redirect) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          // One bubble into EX; the ID instruction is re-checked next cycle.
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (!hz.ihit) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_RUN;
      halt_q    <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state <= next_state;
      if (state != S_DRAIN && next_state == S_DRAIN) begin
        drain_cnt <= CW'(DRAIN_CYCLES - 1);
      end else if (state == S_DRAIN && drain_cnt != '0) begin
        drain_cnt <= drain_cnt - 1'b1;
      end
      if (next_state == S_HALTED) halt_q <= 1'b1;
    end
  end

  assign hz.pc_en       = pc_en;
  assign hz.ifid_en     = ifid_en;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_en     = idex_en;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_en    = exmem_en;
  assign hz.exmem_flush = exmem_flush;
  assign hz.memwb_en    = memwb_en;
  assign hz.halt        = halt_q;

`ifdef HAZARD_PERF_EN
  logic stall_inc, flush_inc;
  assign stall_inc = !pc_en && (state != S_HALTED);
  assign flush_inc = apply_flow && hz.ex_redirect;

  hazard_perf_cnt #(.W(PERF_W)) u_stall_cnt (
    .clk (CLK),
    .rst (RST),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  hazard_perf_cnt #(.W(PERF_W)) u_flush_cnt (
    .clk (CLK),
    .rst (RST),
    .inc (flush_inc),
    .cnt (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  localparam int DC = 2;
  localparam int PW = 4;
  localparam int CNT_MAX = (1 << PW) - 1;
`ifdef HAZARD_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  logic [PW-1:0] stall_cnt, flush_cnt;
  int n_cmp = 0;
  int n_bad = 0;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.DRAIN_CYCLES(DC), .PERF_W(PW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .hz        (hz),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 CLK = ~CLK;

  // Reference model: "waiting on memory", "drain cycles left", "frozen".
  bit m_wait, m_halted, m_halt;
  int m_drain, m_stall, m_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit ih, input bit dh, input int rs, input int rt,
                       input bit dren, input int wsel, input bit redir,
                       input bit rd, input bit wr, input bit mh);
    hz.ihit = ih; hz.dhit = dh; hz.ifid_rs = 5'(rs); hz.ifid_rt = 5'(rt);
    hz.idex_DRen = dren; hz.idex_wsel = 5'(wsel); hz.ex_redirect = redir;
    hz.exmem_dREN = rd; hz.exmem_dWEN = wr; hz.mem_halt = mh;
  endtask

  // Expected {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en}
  function automatic logic [7:0] exp_ctl();
    bit lu;
    lu = hz.idex_DRen && hz.idex_wsel != 0 &&
         (hz.idex_wsel == hz.ifid_rs || hz.idex_wsel == hz.ifid_rt);
    if (RST) return 8'b0010_1010;
    if (m_halted) return 8'b0000_0000;
    if (m_drain > 0) return 8'b0001_1111;
    if (m_wait && !hz.dhit) return 8'b0000_0000;
    if (!m_wait && hz.mem_halt) return 8'b0111_1111;
    if (!m_wait && (hz.exmem_dREN || hz.exmem_dWEN) && !hz.dhit) return 8'b0000_0000;
    if (hz.ex_redirect) return 8'b1111_1101;
    if (lu) return 8'b0001_1101;
    if (!hz.ihit) return 8'b0111_0101;
    return 8'b1101_0101;
  endfunction

  task automatic model_edge(input logic [7:0] e);
    bit flowing;
    if (RST) begin
      m_wait = 0; m_drain = 0; m_halted = 0; m_halt = 0; m_stall = 0; m_flush = 0;
      return;
    end
    flowing = !m_halted && m_drain == 0 &&
              (m_wait ? hz.dhit : !hz.mem_halt && !((hz.exmem_dREN || hz.exmem_dWEN) && !hz.dhit));
    if (!m_halted && !e[7] && m_stall < CNT_MAX) m_stall++;
    if (flowing && hz.ex_redirect && m_flush < CNT_MAX) m_flush++;
    if (m_halted) begin
    end else if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) begin m_halted = 1; m_halt = 1; end
    end else if (m_wait) begin
      if (hz.dhit) m_wait = 0;
    end else if (hz.mem_halt) begin
      m_drain = DC;
    end else if ((hz.exmem_dREN || hz.exmem_dWEN) && !hz.dhit) begin
      m_wait = 1;
    end
  endtask

  task automatic step(input string tag);
    logic [7:0] e;
    @(negedge CLK);
    e = exp_ctl();
    chk({tag, ".ctl"}, 32'({hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_en, hz.idex_flush,
                            hz.exmem_en, hz.exmem_flush, hz.memwb_en}), 32'(e));
    chk({tag, ".halt"}, 32'(hz.halt), 32'(m_halt));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), PERF_ON ? 32'(m_stall) : 32'd0);
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), PERF_ON ? 32'(m_flush) : 32'd0);
    @(posedge CLK);
    model_edge(e);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    model_edge(8'h00);
    #1;
    step("reset");
    RST = 1'b0;
    drive(1, 1, 1, 2, 0, 3, 0, 0, 0, 0); step("normal");
    // Load-use on rs, then the bubble has reached EX
    drive(1, 1, 5, 7, 1, 5, 0, 0, 0, 0); step("loaduse");
    drive(1, 1, 5, 7, 0, 0, 0, 0, 0, 0); step("after_lu");
    // Load writing $0 is never a hazard
    drive(1, 1, 3, 0, 1, 0, 0, 0, 0, 0); step("lu_r0");
    // Redirect overrides load-use
    drive(1, 1, 4, 9, 1, 9, 1, 0, 0, 0); step("redir_lu");
    drive(0, 1, 1, 2, 0, 3, 0, 0, 0, 0); step("imiss");
    // Cache miss with redirect held in EX for the whole wait
    drive(1, 0, 1, 2, 0, 3, 1, 1, 0, 0);
    repeat (3) step("dmiss");
    drive(1, 1, 1, 2, 0, 3, 1, 1, 0, 0); step("dhit_redir");
    drive(1, 1, 1, 2, 0, 3, 0, 0, 0, 0); step("post_wait");
    // Halt drain and freeze
    drive(1, 1, 1, 2, 0, 3, 0, 0, 0, 1); step("halt_mem");
    drive(1, 1, 1, 2, 0, 3, 0, 0, 0, 0);
    for (int i = 0; i < DC + 2; i++) step("drain");
    for (int i = 0; i < 6; i++) begin
      drive(i[0], i[1], 1, 2, 1, 1, ~i[0], i[1], 0, i[2]);
      step("frozen");
    end
    // Reset in the middle of a drain
    drive(1, 1, 1, 2, 0, 3, 0, 0, 0, 1); step("halt2");
    drive(1, 1, 1, 2, 0, 3, 0, 0, 0, 0); step("drain2");
    RST = 1'b1; step("rst_drain");
    RST = 1'b0; step("after_rst");
    // Randomized traffic, including counter saturation and occasional resets
    for (int i = 0; i < 600; i++) begin
      RST = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            $urandom_range(0, 1) != 0, int'($urandom_range(0, 3)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
      step("rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
